// File: rtl/opo_package.sv
// Shared types and constants for the OPO locking chain.
package opo_package;

  localparam int word_width     = 16;
  localparam int LOCKIN_SHIFT_W = 5;

  typedef enum logic {
    IDLE,
    ACCUM
  } lockin_state_t;

endpackage

// File: rtl/opo_lockin_accumulator_saturate.sv
// Arithmetic right shift followed by a signed narrowing to OUT_W bits.
// With OPO_LOCKIN_SAT_EN defined the narrowing clamps; otherwise it wraps.
module lockin_saturate
  import opo_package::*;
#(
  parameter int IN_W  = 33,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]           din,
  input  logic        [LOCKIN_SHIFT_W-1:0] shift,
  output logic signed [OUT_W-1:0]          dout,
  output logic                             clamped
);

  logic signed [IN_W-1:0] shifted;

  assign shifted = din >>> shift;

`ifdef OPO_LOCKIN_SAT_EN
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    dout    = shifted[OUT_W-1:0];
    clamped = 1'b0;
    if (shifted > MAX_V) begin
      dout    = MAX_V[OUT_W-1:0];
      clamped = 1'b1;
    end else if (shifted < MIN_V) begin
      dout    = MIN_V[OUT_W-1:0];
      clamped = 1'b1;
    end
  end
`else
  logic [IN_W-OUT_W-1:0] unused_hi;

  assign dout      = shifted[OUT_W-1:0];
  assign clamped   = 1'b0;
  assign unused_hi = shifted[IN_W-1:OUT_W];
`endif

endmodule

// File: rtl/opo_lockin_accumulator.sv
// Dither lock-in integrator: +/-1 demodulation and windowed integration.
// Saturation and the sticky overflow flag are enabled by OPO_LOCKIN_SAT_EN.
module opo_lockin_accumulator
  import opo_package::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic        [LEN_WIDTH-1:0]      period_len,
  input  logic        [LOCKIN_SHIFT_W-1:0] out_shift,
  input  logic                             ref_phase,
  input  logic signed [word_width-1:0]     sample_in,
  input  logic                             sample_in_valid,
  output logic signed [word_width-1:0]     err_out,
  output logic                             err_out_valid,
  output logic                             acc_overflow,
  input  logic                             clear_overflow
);

  lockin_state_t                 state, state_next;
  logic signed [ACC_WIDTH-1:0]   acc, acc_next;
  logic        [LEN_WIDTH-1:0]   cnt, cnt_next;
  logic        [LEN_WIDTH-1:0]   len_q, len_next;
  logic        [LEN_WIDTH-1:0]   len_eff;
  logic signed [word_width-1:0]  err_next;
  logic                          valid_next;
  logic                          ovf_set;
  logic                          window_last;

  logic signed [ACC_WIDTH:0]     ext, term, sum;
  logic signed [ACC_WIDTH-1:0]   acc_sat;
  logic signed [word_width-1:0]  word_sat;
  logic                          acc_clamp, word_clamp;

  // Extending before negating keeps -(most negative sample) exact.
  assign ext  = {{(ACC_WIDTH+1-word_width){sample_in[word_width-1]}}, sample_in};
  assign term = ref_phase ? ext : -ext;
  assign sum  = {acc[ACC_WIDTH-1], acc} + term;

  assign len_eff     = (period_len == '0) ? LEN_WIDTH'(1) : period_len;
  assign window_last = (cnt == len_q - 1'b1);

  lockin_saturate #(
    .IN_W  (ACC_WIDTH + 1),
    .OUT_W (ACC_WIDTH)
  ) u_sat_acc (
    .din     (sum),
    .shift   ({LOCKIN_SHIFT_W{1'b0}}),
    .dout    (acc_sat),
    .clamped (acc_clamp)
  );

  lockin_saturate #(
    .IN_W  (ACC_WIDTH + 1),
    .OUT_W (word_width)
  ) u_sat_word (
    .din     (sum),
    .shift   (out_shift),
    .dout    (word_sat),
    .clamped (word_clamp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      len_q         <= LEN_WIDTH'(1);
      err_out       <= '0;
      err_out_valid <= 1'b0;
    end else begin
      state         <= state_next;
      acc           <= acc_next;
      cnt           <= cnt_next;
      len_q         <= len_next;
      err_out       <= err_next;
      err_out_valid <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    len_next   = len_q;
    err_next   = err_out;
    valid_next = 1'b0;
    ovf_set    = 1'b0;
    case (state)
      IDLE: begin
        acc_next = '0;
        cnt_next = '0;
        if (enable) begin
          len_next   = len_eff;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        // Dropping enable abandons the partial window without a result.
        if (!enable) begin
          state_next = IDLE;
          acc_next   = '0;
          cnt_next   = '0;
        end else if (sample_in_valid) begin
          if (window_last) begin
            err_next   = word_sat;
            valid_next = 1'b1;
            ovf_set    = word_clamp;
            acc_next   = '0;
            cnt_next   = '0;
            len_next   = len_eff;
          end else begin
            acc_next = acc_sat;
            ovf_set  = acc_clamp;
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef OPO_LOCKIN_SAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_overflow <= 1'b0;
    end else if (ovf_set) begin
      acc_overflow <= 1'b1;
    end else if (clear_overflow) begin
      acc_overflow <= 1'b0;
    end
  end
`else
  logic [1:0] unused_ovf;

  assign acc_overflow = 1'b0;
  assign unused_ovf   = {clear_overflow, ovf_set};
`endif

endmodule

// File: tb/tb_opo_lockin_accumulator.sv
// Randomised scoreboard bench for opo_lockin_accumulator against an arithmetic model.
`timescale 1ns/1ps
module tb_opo_lockin_accumulator;
  import opo_package::*;

  localparam int ACC_W = 16;
  localparam int LEN_W = 16;

  logic                          clk = 1'b0;
  logic                          rst = 1'b0;
  logic                          enable = 1'b0;
  logic        [LEN_W-1:0]       period_len = '0;
  logic        [LOCKIN_SHIFT_W-1:0] out_shift = '0;
  logic                          ref_phase = 1'b0;
  logic signed [word_width-1:0]  sample_in = '0;
  logic                          sample_in_valid = 1'b0;
  logic signed [word_width-1:0]  err_out;
  logic                          err_out_valid;
  logic                          acc_overflow;
  logic                          clear_overflow = 1'b0;

  int errors = 0;
  int checks = 0;
  string cur_test = "reset";

  longint exp_q[$];
  bit     m_active;
  longint m_acc;
  int     m_cnt;
  int     m_len;
  bit     m_ovf;
  bit     m_pulse;
  longint m_err;

  always #5 clk = ~clk;

  opo_lockin_accumulator #(
    .ACC_WIDTH (ACC_W),
    .LEN_WIDTH (LEN_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .period_len      (period_len),
    .out_shift       (out_shift),
    .ref_phase       (ref_phase),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .err_out         (err_out),
    .err_out_valid   (err_out_valid),
    .acc_overflow    (acc_overflow),
    .clear_overflow  (clear_overflow)
  );

  // Narrow a mathematically exact value to w signed bits.
  function automatic longint narrow(input longint v, input int w, output bit clamped);
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint lo = -(longint'(1) << (w - 1));
    longint m  = longint'(1) << w;
    longint r;
    clamped = 1'b0;
`ifdef OPO_LOCKIN_SAT_EN
    if (v > hi) begin r = hi; clamped = 1'b1; end
    else if (v < lo) begin r = lo; clamped = 1'b1; end
    else r = v;
`else
    r = v & (m - 1);
    if (r > hi) r = r - m;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_acc    = 0;
    m_cnt    = 0;
    m_len    = 1;
    m_ovf    = 1'b0;
    m_pulse  = 1'b0;
    m_err    = 0;
  endtask

  task automatic model_step(input bit en, input bit vld, input longint smp, input bit ph,
                            input int len, input int sh, input bit clr);
    bit set = 1'b0;
    bit c;
    longint sum;
    m_pulse = 1'b0;
    if (!m_active) begin
      m_acc = 0;
      m_cnt = 0;
      if (en) begin
        m_len    = (len == 0) ? 1 : len;
        m_active = 1'b1;
      end
    end else if (!en) begin
      m_active = 1'b0;
      m_acc    = 0;
      m_cnt    = 0;
    end else if (vld) begin
      sum = m_acc + (ph ? smp : -smp);
      if (m_cnt == m_len - 1) begin
        m_err   = narrow(sum >>> sh, word_width, c);
        set     = c;
        m_pulse = 1'b1;
        exp_q.push_back(m_err);
        m_acc   = 0;
        m_cnt   = 0;
        m_len   = (len == 0) ? 1 : len;
      end else begin
        m_acc = narrow(sum, ACC_W, c);
        set   = c;
        m_cnt = m_cnt + 1;
      end
    end
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic checkOutput();
    checks++;
    if (longint'(err_out) !== m_err) begin
      errors++;
      $display("[TB] FAIL %s err_out: got %0d expected %0d", cur_test, err_out, m_err);
    end
    checks++;
    if (err_out_valid !== m_pulse) begin
      errors++;
      $display("[TB] FAIL %s err_out_valid: got %0b expected %0b", cur_test, err_out_valid, m_pulse);
    end
    checks++;
    if (acc_overflow !== m_ovf) begin
      errors++;
      $display("[TB] FAIL %s acc_overflow: got %0b expected %0b", cur_test, acc_overflow, m_ovf);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit vld, input longint smp, input bit ph,
                               input int len, input int sh, input bit clr);
    @(negedge clk);
    enable          = en;
    sample_in_valid = vld;
    sample_in       = word_width'(smp);
    ref_phase       = ph;
    period_len      = LEN_W'(len);
    out_shift       = LOCKIN_SHIFT_W'(sh);
    clear_overflow  = clr;
    model_step(en, vld, smp, ph, len, sh, clr);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest predicted result.
  always @(negedge clk) begin
    if (rst && err_out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s unexpected pulse: got err_out=%0d expected no pulse", cur_test, err_out);
      end else begin
        longint e;
        e = exp_q.pop_front();
        if (longint'(err_out) !== e) begin
          errors++;
          $display("[TB] FAIL %s scoreboard: got %0d expected %0d", cur_test, err_out, e);
        end
      end
    end
  end

  initial begin
    longint s4[4];
    model_reset();
    #1;
    checkOutput();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;

    cur_test = "basic";
    s4 = '{10, 20, -5, 3};
    applyStimulus(1, 1, 99, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, s4[i], 1, 4, 0, 0);

    cur_test = "ref_phase";
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, s4[i], (i % 2) == 0, 4, 0, 0);
    cur_test = "no_gap";
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 100 * (i + 1), 1, 4, 0, 0);
    applyStimulus(0, 0, 0, 1, 4, 0, 0);

    cur_test = "zero_len";
    applyStimulus(1, 0, 0, 1, 0, 2, 0);
    applyStimulus(1, 1, 7, 1, 0, 2, 0);
    applyStimulus(1, 1, -9, 1, 0, 2, 0);
    applyStimulus(0, 0, 0, 1, 0, 2, 0);

    cur_test = "enable_drop";
    applyStimulus(1, 0, 0, 1, 8, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1000, 1, 8, 0, 0);
    applyStimulus(0, 1, 1000, 1, 8, 0, 0);
    applyStimulus(1, 0, 0, 1, 8, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, i + 1, 1, 8, 0, 0);

    cur_test = "saturation";
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 32767, 1, 8, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 8, 0, 0);
    applyStimulus(1, 0, 0, 1, 8, 0, 1);
    applyStimulus(1, 0, 0, 1, 8, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, -32768, 0, 8, 0, 0);
    applyStimulus(1, 1, -32768, 1, 2, 0, 1);
    applyStimulus(1, 1, -32768, 1, 2, 0, 1);
    applyStimulus(0, 0, 0, 1, 4, 0, 1);
    applyStimulus(0, 0, 0, 1, 4, 0, 0);

    cur_test = "reset_mid";
    applyStimulus(1, 0, 0, 1, 4, 0, 0);
    applyStimulus(1, 1, 500, 1, 4, 0, 0);
    applyStimulus(1, 1, 600, 1, 4, 0, 0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    checkOutput();
    @(negedge clk);
    #2 rst = 1'b1;
    applyStimulus(1, 0, 0, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 3 * (i + 1), 1, 4, 1, 0);

    cur_test = "random";
    for (int n = 0; n < 3000; n++) begin
      bit     en  = ($urandom_range(0, 39) != 0);
      bit     vld = ($urandom_range(0, 3) != 0);
      bit     ph  = $urandom_range(0, 1);
      int     len = $urandom_range(0, 5);
      int     sh  = $urandom_range(0, 4);
      bit     clr = ($urandom_range(0, 15) == 0);
      longint smp;
      if ($urandom_range(0, 7) == 0) smp = longint'($urandom_range(0, 65535)) - 32768;
      else smp = longint'($urandom_range(0, 4000)) - 2000;
      applyStimulus(en, vld, smp, ph, len, sh, clr);
    end

    cur_test = "drain";
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending results: got %0d expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/opo_lockin_accumulator.md
# opo_lockin_accumulator

Dither lock-in integrator placed directly downstream of the two-sample moving-average stage in the OPO locking chain. It consumes the averaged `word_width` sample stream, multiplies each sample by ±1 according to the dither reference phase, and integrates over a programmable window. At the end of each window it emits one scaled, saturated error word for the lock controller.

## Interface
- `ACC_WIDTH`, 32: accumulator width in bits; must be ≥ `word_width` + `LEN_WIDTH`.
- `LEN_WIDTH`, 16: width of the window-length input.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = integrate; 0 = idle, accumulator held at 0.
- `period_len`  in  `LEN_WIDTH`  valid samples per window; 0 is treated as 1.
- `out_shift`  in  5  arithmetic right shift applied to the accumulator before output.
- `ref_phase`  in  1  dither reference: 1 = add the sample, 0 = subtract it.
- `sample_in`  in  `word_width`  signed two's-complement sample from the averager.
- `sample_in_valid`  in  1  sample strobe.
- `err_out`  out  `word_width`  signed error word.
- `err_out_valid`  out  1  one-cycle pulse per completed window.
- `acc_overflow`  out  1  sticky flag: accumulator or output saturated.
- `clear_overflow`  in  1  synchronous clear of `acc_overflow`.

## Operation
- States are `IDLE` and `ACCUM`.
- Every output resets to 0. Internally, `acc` = 0, `cnt` = 0 and `len_q` = 1 at reset.
- **IDLE:**
  - `acc` and `cnt` are held at 0.
  - When `enable` = 1, latch `len_q` = max(`period_len`, 1) and go to `ACCUM`.
  - Samples that arrive in the latch cycle are dropped.
- **ACCUM**, on each `sample_in_valid`:
  - term = sign-extended `sample_in`, negated when `ref_phase` = 0.
  - sum = `acc` + term, computed at `ACC_WIDTH`+1 bits.
  - `cnt` increments.
- **Window end:** when `cnt` = `len_q`−1 and a valid sample arrives:
  - `err_out` = sat_word(sum >>> `out_shift`).
  - `err_out_valid` = 1.
  - `acc` = 0 and `cnt` = 0.
  - `len_q` re-latches from `period_len`, with 0 treated as 1.
  - There are no idle cycles between windows.
- **Other valid samples in `ACCUM`:** `acc` = sat_acc(sum).
- **Negation edge case:** negating the most negative `word_width` value is exact, because the extension happens before the negation.
- **`enable` falling in `ACCUM`:**
  - Go to `IDLE` on the next edge and discard the partial window.
  - No `err_out_valid` is issued.
  - `err_out` keeps its last value.
- **Changes mid-window:** a `period_len` change takes effect at the next window. `out_shift` is sampled at the window-end cycle.
- **`acc_overflow`:**
  - Set whenever sat_acc or sat_word clamps.
  - `clear_overflow` clears it.
  - If set and clear happen in the same cycle, set wins.

## Timing
- Latency: `err_out`/`err_out_valid` update on the same edge that accepts the final sample of the window, which is one clock after that sample is presented.
- `err_out_valid` is high for exactly one cycle per window.
- Throughput: one sample per clock, back-to-back, with no gaps at window boundaries.
- Asynchronous reset mid-window returns to `IDLE` immediately with all state at 0.

## Configuration
- Macro: `OPO_LOCKIN_SAT_EN`.
- **Defined:**
  - sat_acc clamps to [−2^(`ACC_WIDTH`−1), 2^(`ACC_WIDTH`−1)−1].
  - sat_word clamps to the `word_width` signed range.
  - `acc_overflow` operates as described in Operation.
- **Undefined:**
  - Both operations truncate and wrap in two's complement.
  - `acc_overflow` is tied to 0.
  - `clear_overflow` is ignored.

## Structure
- `opo_package`:
  - Supplies `word_width`.
  - Gains `lockin_state_t` (`IDLE`, `ACCUM`).
  - Gains the constant `LOCKIN_SHIFT_W` = 5.
- Sub-module `lockin_saturate`:
  - Combinational.
  - Parameterised input and output widths.
  - Performs the arithmetic right shift and the signed clamp, and outputs a clamp flag.
  - Instantiated twice: once for sat_acc (shift 0), once for sat_word.

## Test plan
- **Basic window:** `period_len`=4, `out_shift`=0, `ref_phase`=1, samples 10, 20, −5, 3 back-to-back → `err_out`=28 with one valid pulse, on the edge that accepts the 4th sample.
- **Reference phase:** same as basic window, with `ref_phase` toggling 1, 0, 1, 0 → `err_out` = 10 − 20 − 5 − 3 = −18. Then a second window starts with no gap.
- **Zero length and shift:** `period_len`=0, `out_shift`=2, samples 7, −9 → outputs 1 and −3 on consecutive cycles.
- **Enable drop:** `period_len`=8; drop `enable` after 5 samples, then raise it again → no valid pulse, and the next window's result excludes the earlier 5 samples.
- **Saturation:** with `ACC_WIDTH`=16 and `OPO_LOCKIN_SAT_EN` defined, feed the maximum positive sample repeatedly → `acc` pins at 32767, `err_out` = `word_width` maximum, `acc_overflow` is sticky until `clear_overflow`. Without the macro, `acc` wraps and `acc_overflow` stays 0.
- **Reset mid-window:** assert `rst` after 2 of 4 samples → all outputs go to 0 and the first window after reset uses only post-reset samples.
